// File: rtl/adder_pkg.sv
// Shared types and constants for the multi-byte add/subtract sequencer.
package adder_pkg;
    localparam int BYTE_W            = 8;
    localparam int MAX_BEATS_DEFAULT = 16;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;
endpackage

// File: rtl/adder_carry_mini.sv
// 8-bit carry-lookahead adder: every carry is a flat sum of generate/propagate products.
module adder_carry_mini
    import adder_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W-1:0] gen;
    logic [BYTE_W-1:0] prop;
    logic [BYTE_W:0]   carry;
    logic              chainP;
    logic              chainC;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Carry into bit i+1 is g[i] | p[i]g[i-1] | ... | p[i..0]cin, expanded per bit.
    always_comb begin
        carry    = '0;
        chainP   = 1'b1;
        chainC   = 1'b0;
        carry[0] = cin;
        for (int i = 0; i < BYTE_W; i++) begin
            chainP = 1'b1;
            chainC = 1'b0;
            for (int j = i; j >= 0; j--) begin
                chainC = chainC | (chainP & gen[j]);
                chainP = chainP & prop[j];
            end
            carry[i+1] = chainC | (chainP & cin);
        end
    end

    assign sum  = prop ^ carry[BYTE_W-1:0];
    assign cout = carry[BYTE_W];

endmodule

// File: rtl/adder_carry_seq.sv
// Byte-serial add/subtract sequencer: chains carry across beats into a one-entry
// registered result stage with valid/ready handshakes on both sides.
module adder_carry_seq
    import adder_pkg::*;
#(
    parameter int MAX_BEATS = MAX_BEATS_DEFAULT,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_a,
    input  logic [BYTE_W-1:0] in_b,
    input  logic              in_first,
    input  logic              in_last,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_cout,
    output logic              out_ovf,
    output logic              out_err
);

    state_e            state_q, state_d;
    logic              carry_q, carry_d;
    logic              sub_q, sub_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic              out_valid_q, out_valid_d;
    logic [BYTE_W-1:0] out_sum_q, out_sum_d;
    logic              out_last_q, out_last_d;
    logic              out_cout_q, out_cout_d;
    logic              out_ovf_q, out_ovf_d;
    logic              out_err_q, out_err_d;

    logic              accept;
    logic              isIdle;
    logic              isFirst;
    logic              subEff;
    logic              cin;
    logic [BYTE_W-1:0] bEff;
    logic [BYTE_W-1:0] sum;
    logic              cout;
    logic              ovf;
    logic [CNT_W-1:0]  beatNum;
    logic              forced;
    logic              lastBeat;
    logic              seqErr;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Any beat seen in IDLE starts a new operation, whether or not it is flagged first.
    assign isIdle   = (state_q == ST_IDLE);
    assign isFirst  = isIdle || in_first;
    assign subEff   = isFirst ? in_sub : sub_q;
    assign cin      = isFirst ? in_sub : carry_q;
    assign bEff     = subEff ? ~in_b : in_b;
    assign beatNum  = isFirst ? CNT_W'(1) : beat_cnt_q + CNT_W'(1);
    assign forced   = (beatNum == CNT_W'(MAX_BEATS)) && !in_last;
    assign lastBeat = in_last || forced;
    assign seqErr   = (isIdle != in_first) || forced;
    assign ovf      = (in_a[BYTE_W-1] == bEff[BYTE_W-1]) && (sum[BYTE_W-1] != in_a[BYTE_W-1]);

    adder_carry_mini u_adder (
        .a    (in_a),
        .b    (bEff),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        sub_d       = sub_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;
        out_err_d   = out_err_q;
        if (accept) begin
            state_d     = lastBeat ? ST_IDLE : ST_BUSY;
            carry_d     = cout;
            sub_d       = subEff;
            beat_cnt_d  = beatNum;
            out_valid_d = 1'b1;
            out_sum_d   = sum;
            out_last_d  = lastBeat;
            out_cout_d  = lastBeat && cout;
            out_ovf_d   = lastBeat && ovf;
            out_err_d   = seqErr;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_adder_carry_seq.sv
// Bench for adder_carry_seq: directed and random operations checked against a
// whole-operand arithmetic model, with random and forced output backpressure.
module tb_adder_carry_seq;

    localparam int MAXB = 16;

    typedef struct packed {
        logic [7:0] sum;
        logic       last;
        logic       cout;
        logic       ovf;
        logic       err;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_first;
    logic       in_last;
    logic       in_sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_last;
    logic       out_cout;
    logic       out_ovf;
    logic       out_err;

    int checkCount = 0;
    int failCount  = 0;
    int readyMode  = 1;

    beat_t expQ[$];

    logic         mIdle;
    logic         mSub;
    int           mN;
    logic [135:0] mA;
    logic [135:0] mB;

    adder_carry_seq #(.MAX_BEATS(MAXB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mIdle = 1'b1;
        mSub  = 1'b0;
        mN    = 0;
        mA    = '0;
        mB    = '0;
    endtask

    // Reference: accumulate full-width operands and take byte n-1 of A+B or A-B.
    task automatic modelBeat(input logic [7:0] a, input logic [7:0] b,
                             input logic first, input logic last, input logic sub);
        beat_t        e;
        logic [135:0] r;
        logic [135:0] t;
        logic         sA, sB, sR, isNew, forced;
        isNew   = mIdle || first;
        e.err   = (mIdle && !first) || (!mIdle && first);
        if (isNew) begin
            mA   = '0;
            mB   = '0;
            mN   = 0;
            mSub = sub;
        end
        mA     = mA | (136'(a) << (8 * mN));
        mB     = mB | (136'(b) << (8 * mN));
        mN     = mN + 1;
        forced = (mN == MAXB) && !last;
        r      = mSub ? (mA - mB) : (mA + mB);
        t      = r >> (8 * (mN - 1));
        e.sum  = t[7:0];
        e.last = last || forced;
        if (mSub) begin
            e.cout = (mA >= mB);
        end else begin
            t      = (mA + mB) >> (8 * mN);
            e.cout = t[0];
        end
        t  = mA >> (8 * mN - 1);
        sA = t[0];
        t  = mB >> (8 * mN - 1);
        sB = t[0];
        t  = r >> (8 * mN - 1);
        sR = t[0];
        e.ovf  = mSub ? ((sA != sB) && (sR != sA)) : ((sA == sB) && (sR != sA));
        e.cout = e.cout && e.last;
        e.ovf  = e.ovf && e.last;
        e.err  = e.err || forced;
        mIdle  = e.last;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic first, input logic last, input logic sub);
        bit taken = 1'b0;
        in_a     = a;
        in_b     = b;
        in_first = first;
        in_last  = last;
        in_sub   = sub;
        in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                modelBeat(a, b, first, last, sub);
                taken = 1'b1;
                break;
            end
        end
        if (!taken) checkOutput("in_ready_timeout", 32'(taken), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drainOutputs();
        bit done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (expQ.size() == 0 && out_valid !== 1'b1) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) checkOutput("drain_timeout", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic runOp();
        int len  = $urandom_range(1, 18);
        int mode = $urandom_range(0, 9);
        logic f, l;
        for (int k = 0; k < len; k++) begin
            f = (k == 0);
            if (mode == 0 && k == 0) f = 1'b0;
            if (mode == 1 && len > 1 && k == len / 2) f = 1'b1;
            l = (k == len - 1) && (len <= MAXB);
            applyStimulus(8'($urandom), 8'($urandom), f, l, 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                1:       out_ready = 1'b1;
                2:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Output monitor: consume beats on handshake, and require a stalled beat to hold.
    initial begin
        beat_t cur;
        beat_t held;
        beat_t e;
        bit    holdValid = 1'b0;
        forever begin
            @(negedge clk);
            cur = '{sum: out_sum, last: out_last, cout: out_cout, ovf: out_ovf, err: out_err};
            if (holdValid && out_valid === 1'b1) checkOutput("hold_stable", 32'(cur), 32'(held));
            if (out_valid === 1'b1 && out_ready === 1'b0) begin
                checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
                holdValid = 1'b1;
                held      = cur;
            end else begin
                holdValid = 1'b0;
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sum",  32'(out_sum),  32'(e.sum));
                    checkOutput("last", 32'(out_last), 32'(e.last));
                    checkOutput("cout", 32'(out_cout), 32'(e.cout));
                    checkOutput("ovf",  32'(out_ovf),  32'(e.ovf));
                    checkOutput("err",  32'(out_err),  32'(e.err));
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_sum",   32'(out_sum),   32'd0);
        checkOutput("rst_out_flags", 32'({out_last, out_cout, out_ovf, out_err}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] directed arithmetic");
        applyStimulus(8'hFF, 8'h01, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h00, 8'h01, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h7F, 8'h01, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'h80, 8'h01, 1'b1, 1'b1, 1'b1);

        $display("[TB] sequencing errors");
        applyStimulus(8'hF0, 8'h20, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'hF0, 8'h40, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h55, 8'h66, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < MAXB; k++) begin
            applyStimulus(8'($urandom), 8'($urandom), k == 0, 1'b0, 1'b0);
        end
        applyStimulus(8'h01, 8'h02, 1'b1, 1'b1, 1'b0);

        $display("[TB] backpressure");
        drainOutputs();
        readyMode = 2;
        @(posedge clk);
        #1;
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        readyMode = 1;
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h7F, 8'h00, 1'b0, 1'b1, 1'b0);

        $display("[TB] reset mid-operation");
        drainOutputs();
        applyStimulus(8'h11, 8'h22, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
        expQ.delete();
        modelReset();
        applyStimulus(8'h33, 8'h44, 1'b0, 1'b1, 1'b0);

        $display("[TB] random operations");
        readyMode = 0;
        repeat (40) runOp();
        readyMode = 1;
        @(posedge clk);
        #1;
        drainOutputs();
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
